arb_req_ctrl: RTL and testbench

Upstream request controller for the three-client `arbiter`. Each client posts a transfer length into a small per-client queue. The block drives the arbiter's `r[1:3]` lines, counts the granted beats for each transfer, and releases `r[i]` when the transfer completes so lower-priority clients can win. It also reports per-beat qualifiers, completion pulses and a sticky protocol-error flag.

---
 rtl/arb_req_ctrl.sv | 156 +++++++++++++++
 tb/tb_arb_req_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_req_ctrl.sv
// arb_req_ctrl: upstream request controller for the three-client arbiter.
// Each client has a small length queue and an FSM that raises r[i], counts
// granted beats, then drops r[i] and waits for the arbiter to let go.

module arb_req_client #(
    parameter int LEN_WIDTH = 4,
    parameter int DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_valid,
    input  logic [LEN_WIDTH-1:0] i_len,
    input  logic                 i_gnt,
    output logic                 o_ready,
    output logic                 o_req,
    output logic                 o_done,
    output logic                 o_err
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_REL} state_t;

    state_t               r_state, w_state_nxt;
    logic [LEN_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic                 r_req, r_done, w_done_nxt;
    logic [LEN_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]        r_wptr, r_rptr;
    logic [OW-1:0]        r_occ;
    logic                 w_push, w_pop, w_empty;

    assign o_ready = (r_occ != OW'(DEPTH));
    assign w_empty = (r_occ == '0);
    assign w_push  = i_valid & o_ready;
    // Pop only from IDLE, so a same-cycle push never collides with a stale head.
    assign w_pop   = (r_state == S_IDLE) & ~w_empty;
    assign o_req   = r_req;
    assign o_done  = r_done;

    // Queue storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_len;
    end

    // Queue pointers/occupancy and FSM state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_occ   <= '0;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OW'(1);
                2'b01:   r_occ <= r_occ - OW'(1);
                default: r_occ <= r_occ;
            endcase
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            // r is the registered decode of where the FSM is heading.
            r_req   <= (w_state_nxt == S_WAIT) || (w_state_nxt == S_XFER);
            r_done  <= w_done_nxt;
        end
    end

    // Next-state, beat counting and per-client protocol checks.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        o_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A grant to a client that never asked is a protocol error.
                o_err = i_gnt;
                if (w_pop) begin
                    w_cnt_nxt   = r_mem[r_rptr];
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT, S_XFER: begin
                if (i_gnt) begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_REL;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt - LEN_WIDTH'(1);
                        w_state_nxt = S_XFER;
                    end
                end else if (r_state == S_XFER) begin
                    // Arbiter never preempts, so a dropped grant mid-transfer is flagged.
                    o_err = 1'b1;
                end
            end
            S_REL: begin
                // Hold off re-requesting until the trailing grant has gone.
                if (!i_gnt) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end
endmodule

module arb_req_ctrl #(
    parameter int NCLIENT   = 3,
    parameter int LEN_WIDTH = 4,
    parameter int DEPTH     = 2
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [1:NCLIENT]               req_valid,
    input  logic [NCLIENT*LEN_WIDTH-1:0]   req_len,
    output logic [1:NCLIENT]               req_ready,
    input  logic [1:NCLIENT]               g,
    output logic [1:NCLIENT]               r,
    output logic [1:NCLIENT]               beat,
    output logic [1:NCLIENT]               done,
    output logic                           grant_err
);
    logic [1:NCLIENT] w_cl_err;
    logic             w_multi;
    logic             r_err;

    for (genvar gi = 1; gi <= NCLIENT; gi++) begin : g_cl
        arb_req_client #(
            .LEN_WIDTH (LEN_WIDTH),
            .DEPTH     (DEPTH)
        ) u_client (
            .clk     (clk),
            .rstn    (rstn),
            .i_valid (req_valid[gi]),
            .i_len   (req_len[(gi-1)*LEN_WIDTH +: LEN_WIDTH]),
            .i_gnt   (g[gi]),
            .o_ready (req_ready[gi]),
            .o_req   (r[gi]),
            .o_done  (done[gi]),
            .o_err   (w_cl_err[gi])
        );
    end

    assign beat      = r & g;
    // More than one grant bit set: clearing the lowest set bit leaves something.
    assign w_multi   = |(g & (g - NCLIENT'(1)));
    assign grant_err = r_err;

    // Sticky protocol-error flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rstn)                       r_err <= 1'b0;
        else if (w_multi || |w_cl_err)   r_err <= 1'b1;
    end
endmodule

// File: tb/tb_arb_req_ctrl.sv
// Bench for arb_req_ctrl: a fixed-priority non-preemptive arbiter drives g,
// a transaction-level model predicts every output each cycle, and directed
// scenarios add hand-computed literal checks.
module tb_arb_req_ctrl;
    localparam int LW = 4;
    localparam int DP = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic [1:3]    req_valid, req_ready, g, r, beat, done;
    logic [3*LW-1:0] req_len;
    logic          grant_err;
    logic [1:3]    ag, force_g;
    logic          force_en;

    arb_req_ctrl #(.NCLIENT(3), .LEN_WIDTH(LW), .DEPTH(DP)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_len(req_len),
        .req_ready(req_ready), .g(g), .r(r), .beat(beat), .done(done),
        .grant_err(grant_err)
    );

    always #5 clk = ~clk;

    assign g = force_en ? force_g : ag;

    // Arbiter: registered, client 1 highest, holds a grant while its request stays up.
    always @(posedge clk) begin
        if (!rstn)              ag <= '0;
        else if ((ag & r) != 0) ag <= ag;
        else if (r[1])          ag <= 3'b100;
        else if (r[2])          ag <= 3'b010;
        else if (r[3])          ag <= 3'b001;
        else                    ag <= '0;
    end

    // Transaction model: per client a length queue, beats left, and whether the
    // arbiter still owes a trailing grant cycle after the transfer ended.
    logic [1:3] m_r, m_done, m_rdy;
    logic       m_err;
    bit         model_ok = 1'b0;
    int         mq [1:3][0:DP-1];
    int         msz [1:3];
    int         mleft [1:3];
    bit         mtail [1:3];
    bit         mgot [1:3];

    always @(posedge clk) begin
        logic [1:3] gs;
        bit         rdy;
        gs = g;
        if (!rstn) begin
            m_r = '0; m_done = '0; m_rdy = '1; m_err = 1'b0;
            for (int i = 1; i <= 3; i++) begin
                msz[i] = 0; mleft[i] = 0; mtail[i] = 0; mgot[i] = 0;
            end
        end else begin
            m_done = '0;
            if ($countones(gs) > 1) m_err = 1'b1;
            for (int i = 1; i <= 3; i++) begin
                rdy = (msz[i] < DP);
                if (m_r[i]) begin
                    if (gs[i]) begin
                        mgot[i] = 1;
                        mleft[i]--;
                        if (mleft[i] == 0) begin
                            m_r[i] = 1'b0; m_done[i] = 1'b1; mtail[i] = 1;
                        end
                    end else if (mgot[i]) begin
                        m_err = 1'b1;
                    end
                end else if (mtail[i]) begin
                    if (!gs[i]) mtail[i] = 0;
                end else begin
                    if (gs[i]) m_err = 1'b1;
                    if (msz[i] > 0) begin
                        mleft[i] = mq[i][0] + 1;
                        for (int k = 0; k < DP-1; k++) mq[i][k] = mq[i][k+1];
                        msz[i]--;
                        m_r[i] = 1'b1;
                        mgot[i] = 0;
                    end
                end
                if (req_valid[i] && rdy) begin
                    mq[i][msz[i]] = int'(req_len[(i-1)*LW +: LW]);
                    msz[i]++;
                end
                m_rdy[i] = (msz[i] < DP);
            end
        end
        model_ok = 1'b1;
    end

    int checks = 0, failures = 0, cyc = 0;
    int bc [1:3], dc [1:3], rh [1:3], tg [1:3];
    int rise [1:3], grise [1:3], gfall [1:3], lasthi [1:3], mingap [1:3];
    logic [1:3] pr, pg;

    task automatic chk(input string nm, input logic [2:0] got, input logic [2:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, got, expv);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int expv);
        checks++;
        if (got != expv) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, expv);
        end
    endtask

    task automatic chk_true(input string nm, input bit cond, input int got);
        checks++;
        if (!cond) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d (condition not met)", nm, cyc, got);
        end
    endtask

    // Advance one cycle, compare against the model, update event bookkeeping.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (model_ok) begin
            chk("r", r, m_r);
            chk("beat", beat, m_r & g);
            chk("done", done, m_done);
            chk("req_ready", req_ready, m_rdy);
            chk("grant_err", {2'b00, grant_err}, {2'b00, m_err});
        end
        for (int i = 1; i <= 3; i++) begin
            bc[i] += int'(beat[i]);
            dc[i] += int'(done[i]);
            rh[i] += int'(r[i]);
            if (g[i] && !r[i]) tg[i]++;
            if (r[i] && !pr[i]) begin
                rise[i] = cyc;
                if (lasthi[i] >= 0 && (cyc - lasthi[i] - 1) < mingap[i])
                    mingap[i] = cyc - lasthi[i] - 1;
            end
            if (r[i]) lasthi[i] = cyc;
            if (g[i] && !pg[i]) grise[i] = cyc;
            if (!g[i] && pg[i]) gfall[i] = cyc;
        end
        pr = r;
        pg = g;
    endtask

    task automatic push1(input int c, input int len);
        req_valid = '0;
        req_valid[c] = 1'b1;
        req_len[(c-1)*LW +: LW] = LW'(len);
        step();
        req_valid = '0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    initial begin
        int p, n, pushed, stalls, tot;
        int b0 [1:3];
        int d0 [1:3];
        int r0 [1:3];
        int t0 [1:3];
        rstn = 1'b0; req_valid = '0; req_len = '0; force_en = 1'b0; force_g = '0;
        pr = '0; pg = '0;
        for (int i = 1; i <= 3; i++) begin
            bc[i] = 0; dc[i] = 0; rh[i] = 0; tg[i] = 0; rise[i] = -1;
            grise[i] = 0; gfall[i] = 0; lasthi[i] = -1; mingap[i] = 999;
        end
        step(); step();
        chk("rst_r", r, 3'b000);
        chk("rst_done", done, 3'b000);
        chk("rst_ready", req_ready, 3'b111);
        chk("rst_err", {2'b00, grant_err}, 3'b000);
        rstn = 1'b1;
        step();

        // Single transfer, len=3 on client 1.
        b0 = bc; d0 = dc; r0 = rh;
        p = cyc;
        push1(1, 3);
        repeat (12) step();
        chk_int("s1_rise", rise[1], p + 2);
        chk_int("s1_rhigh", rh[1] - r0[1], 5);
        chk_int("s1_beats", bc[1] - b0[1], 4);
        chk_int("s1_done", dc[1] - d0[1], 1);
        chk("s1_r_low", {2'b00, r[1]}, 3'b000);
        chk("s1_err", {2'b00, grant_err}, 3'b000);

        // Priority and release: len=1 on clients 2 and 3 together.
        b0 = bc; d0 = dc; gfall[2] = 0; grise[3] = 0;
        req_valid = 3'b011;
        req_len[1*LW +: LW] = LW'(1);
        req_len[2*LW +: LW] = LW'(1);
        step();
        req_valid = '0;
        repeat (14) step();
        chk_int("s2_beats2", bc[2] - b0[2], 2);
        chk_int("s2_beats3", bc[3] - b0[3], 2);
        chk_int("s2_done2", dc[2] - d0[2], 1);
        tot = (bc[1] - b0[1]) + (bc[2] - b0[2]) + (bc[3] - b0[3]);
        chk_int("s2_total", tot, 4);
        chk_true("s2_g3_after_g2", gfall[2] > 0 && grise[3] >= gfall[2], grise[3]);

        // Queue full: four len=0 pushes on client 1, valid held until accepted.
        b0 = bc; d0 = dc; lasthi[1] = -1; mingap[1] = 999;
        pushed = 0; stalls = 0; n = 0;
        req_len[0 +: LW] = '0;
        while (pushed < 4 && n < 20) begin
            req_valid = 3'b100;
            if (req_ready[1]) pushed++;
            else              stalls++;
            step();
            n++;
        end
        req_valid = '0;
        chk_int("s3_pushed", pushed, 4);
        chk_int("s3_stalls", stalls, 4);
        repeat (30) step();
        chk_int("s3_done", dc[1] - d0[1], 4);
        chk_int("s3_beats", bc[1] - b0[1], 4);
        chk_true("s3_gap", mingap[1] >= 2 && mingap[1] != 999, mingap[1]);

        // Zero-length on client 3 with a trailing grant cycle.
        b0 = bc; d0 = dc; t0 = tg;
        push1(3, 0);
        repeat (10) step();
        chk_int("s4_beats", bc[3] - b0[3], 1);
        chk_int("s4_done", dc[3] - d0[3], 1);
        chk_int("s4_trail", tg[3] - t0[3], 1);
        chk("s4_err", {2'b00, grant_err}, 3'b000);

        // Protocol error: multi-hot grant, then grant to an idle client.
        force_en = 1'b1; force_g = 3'b110;
        step();
        force_en = 1'b0;
        chk("s5_err_set", {2'b00, grant_err}, 3'b001);
        repeat (5) step();
        chk("s5_err_sticky", {2'b00, grant_err}, 3'b001);
        do_reset();
        chk("s5_err_clr", {2'b00, grant_err}, 3'b000);
        step();
        force_en = 1'b1; force_g = 3'b010;
        step();
        force_en = 1'b0;
        chk("s5_idle_gnt", {2'b00, grant_err}, 3'b001);
        do_reset();
        step();

        // Reset mid-transfer: len=15 on client 2, reset after 5 beats.
        b0 = bc;
        push1(2, 15);
        n = 0;
        while ((bc[2] - b0[2]) < 5 && n < 40) begin
            step();
            n++;
        end
        chk_int("s6_pre_beats", bc[2] - b0[2], 5);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("s6_r", r, 3'b000);
        chk("s6_done", done, 3'b000);
        chk("s6_ready", req_ready, 3'b111);
        chk("s6_err", {2'b00, grant_err}, 3'b000);
        b0 = bc;
        repeat (25) step();
        tot = (bc[1] - b0[1]) + (bc[2] - b0[2]) + (bc[3] - b0[3]);
        chk_int("s6_no_beats", tot, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
